// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized sig_in rising edges over a fixed
// window of GATE_CYCLES clk cycles and publishes each result with a valid pulse.
module freq_meter #(
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              s1, s2, s3;
    logic              rise;
    logic              tc;
    logic              at_max;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;

    // Synchronizer plus edge-detect delay; runs regardless of enable.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, as a real shift chain does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign tc     = enable && (gate_cnt == GATE_LAST);
    assign at_max = (edge_cnt == CNT_MAX);

    // An edge seen on the tc cycle is folded into the closing window's result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            sat       <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else if (!enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= tc;
            if (tc) begin
                gate_cnt  <= '0;
                edge_cnt  <= '0;
                sat       <= 1'b0;
                count_out <= at_max ? CNT_MAX : edge_cnt + CNT_W'(rise);
                overflow  <= sat | (at_max & rise);
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                if (rise) begin
                    if (at_max) begin
                        sat <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit and a 4-bit instance share stimulus,
// both with a 100-cycle gate window.
module tb_freq_meter;

    localparam int GATE = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        enable;
    logic [15:0] count_out;
    logic        valid;
    logic        overflow;
    logic [3:0]  count4;
    logic        valid4;
    logic        overflow4;

    int   n_vec = 0;
    int   n_err = 0;
    int   sq_period = 0;
    logic sig_level = 1'b0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .count_out(count_out), .valid(valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .count_out(count4), .valid(valid4), .overflow(overflow4)
    );

    // sig_in source: square wave of sq_period cycles, or static sig_level when 0.
    // Updated on the falling edge so changes made after a rising edge land cleanly.
    initial begin : sig_gen
        int ph;
        ph     = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (sq_period > 0) begin
                ph     = (ph + 1) % sq_period;
                sig_in = (ph < sq_period / 2);
            end else begin
                sig_in = sig_level;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < max_cycles);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        sq_period = 0;
        sig_level = 1'b0;
        #1;
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL rst_async_count: got %0d want 0", count_out); end
        n_vec++; if (valid !== 1'b0)      begin n_err++; $display("FAIL rst_async_valid: got %b want 0", valid); end
        n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL rst_async_ovf: got %b want 0", overflow); end
        repeat (3) tick();
        n_vec++; if (count4 !== 4'd0)     begin n_err++; $display("FAIL rst_count4: got %0d want 0", count4); end
        n_vec++; if (overflow4 !== 1'b0)  begin n_err++; $display("FAIL rst_ovf4: got %b want 0", overflow4); end
    endtask

    task automatic test_square();
        int n;
        sq_period = 10;
        rst       = 1'b1;
        repeat (5) tick();
        enable = 1'b1;
        wait_valid(150, n);
        n_vec++; if (n !== 100)            begin n_err++; $display("FAIL sq_first_gap: got %0d want 100", n); end
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL sq_count: got %0d want 10", count_out); end
        n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL sq_ovf: got %b want 0", overflow); end
        n_vec++; if (count4 !== 4'd10)     begin n_err++; $display("FAIL sq_count4: got %0d want 10", count4); end
        n_vec++; if (overflow4 !== 1'b0)   begin n_err++; $display("FAIL sq_ovf4: got %b want 0", overflow4); end
        tick();
        n_vec++; if (valid !== 1'b0)       begin n_err++; $display("FAIL sq_valid_width: got %b want 0", valid); end
        wait_valid(150, n);
        n_vec++; if (n !== 99)             begin n_err++; $display("FAIL sq_gap2: got %0d want 99", n); end
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL sq_count2: got %0d want 10", count_out); end
        wait_valid(150, n);
        n_vec++; if (n !== 100)            begin n_err++; $display("FAIL sq_gap3: got %0d want 100", n); end
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL sq_count3: got %0d want 10", count_out); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw;
        repeat (50) tick();
        rst = 1'b0;
        #1;
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count_out); end
        n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
        saw = 1'b0;
        repeat (60) begin
            tick();
            if (valid) saw = 1'b1;
        end
        n_vec++; if (saw !== 1'b0)        begin n_err++; $display("FAIL midrst_valid: got %b want 0", saw); end
        rst = 1'b1;
        wait_valid(150, n);
        n_vec++; if (n !== 100)           begin n_err++; $display("FAIL midrst_gap: got %0d want 100", n); end
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL midrst_next_count: got %0d want 10", count_out); end
    endtask

    task automatic test_enable_gap();
        int   n;
        logic saw;
        repeat (70) tick();
        enable = 1'b0;
        saw    = 1'b0;
        repeat (30) begin
            tick();
            if (valid) saw = 1'b1;
        end
        n_vec++; if (saw !== 1'b0)         begin n_err++; $display("FAIL gap_valid: got %b want 0", saw); end
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL gap_hold_count: got %0d want 10", count_out); end
        enable = 1'b1;
        wait_valid(150, n);
        n_vec++; if (n !== 100)            begin n_err++; $display("FAIL gap_reenable_gap: got %0d want 100", n); end
        n_vec++; if (count_out !== 16'd10) begin n_err++; $display("FAIL gap_reenable_count: got %0d want 10", count_out); end
    endtask

    task automatic test_tc_boundary();
        int n;
        // Edge whose rise lands on the tc cycle: belongs to the closing window.
        sq_period = 0;
        sig_level = 1'b0;
        enable    = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        repeat (97) tick();
        sig_level = 1'b1;
        wait_valid(10, n);
        n_vec++; if (n !== 3)             begin n_err++; $display("FAIL tc_in_gap: got %0d want 3", n); end
        n_vec++; if (count_out !== 16'd1) begin n_err++; $display("FAIL tc_in_count: got %0d want 1", count_out); end
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL tc_in_next: got %0d want 0", count_out); end
        // One cycle later: the rise falls into the first cycle of the next window.
        sig_level = 1'b0;
        enable    = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        repeat (98) tick();
        sig_level = 1'b1;
        wait_valid(10, n);
        n_vec++; if (n !== 2)             begin n_err++; $display("FAIL tc_late_gap: got %0d want 2", n); end
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL tc_late_count: got %0d want 0", count_out); end
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd1) begin n_err++; $display("FAIL tc_late_next: got %0d want 1", count_out); end
    endtask

    task automatic test_static();
        int n;
        sig_level = 1'b0;
        enable    = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL low_count1: got %0d want 0", count_out); end
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL low_count2: got %0d want 0", count_out); end
        rst       = 1'b0;
        sig_level = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        wait_valid(150, n);
        n_vec++; if (n !== 100)           begin n_err++; $display("FAIL high_gap: got %0d want 100", n); end
        n_vec++; if (count_out !== 16'd1) begin n_err++; $display("FAIL high_count1: got %0d want 1", count_out); end
        wait_valid(150, n);
        n_vec++; if (count_out !== 16'd0) begin n_err++; $display("FAIL high_count2: got %0d want 0", count_out); end
    endtask

    task automatic test_overflow();
        int n;
        sq_period = 4;
        enable    = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        wait_valid(150, n);
        n_vec++; if (count4 !== 4'd15)     begin n_err++; $display("FAIL ovf_count4: got %0d want 15", count4); end
        n_vec++; if (overflow4 !== 1'b1)   begin n_err++; $display("FAIL ovf_flag4: got %b want 1", overflow4); end
        n_vec++; if (count_out !== 16'd25) begin n_err++; $display("FAIL ovf_count16: got %0d want 25", count_out); end
        n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL ovf_flag16: got %b want 0", overflow); end
        sq_period = 20;
        wait_valid(150, n);
        n_vec++; if (n !== 100)            begin n_err++; $display("FAIL ovf_mixed_gap: got %0d want 100", n); end
        wait_valid(150, n);
        n_vec++; if (count4 !== 4'd5)      begin n_err++; $display("FAIL slow_count4: got %0d want 5", count4); end
        n_vec++; if (overflow4 !== 1'b0)   begin n_err++; $display("FAIL slow_flag4: got %b want 0", overflow4); end
        n_vec++; if (count_out !== 16'd5)  begin n_err++; $display("FAIL slow_count16: got %0d want 5", count_out); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_reset_mid();
        test_enable_gap();
        test_tc_boundary();
        test_static();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000, which sets the gate window length in clk cycles (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of the edge counter and of count_out.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port sig_in, input, 1 bit: the signal under measurement, asynchronous to clk (for example, a divided clock).
REQ-006 The block SHALL have port enable, input, 1 bit: measurement runs while this port is 1.
REQ-007 The block SHALL have port count_out, output, CNT_W bits: the number of sig_in rising edges in the last completed window.
REQ-008 The block SHALL have port valid, output, 1 bit: a one-cycle pulse marking that count_out has just been updated.
REQ-009 The block SHALL have port overflow, output, 1 bit: set when the last completed window saturated the edge counter.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer (s1, then s2), then through a delay flop (s3).
REQ-011 Rise SHALL be defined combinationally as s2 AND NOT s3.
REQ-012 A sig_in rising edge that is stable before clock edge N SHALL increment the edge counter at edge N+2.
REQ-013 While enable=1, gate_cnt SHALL count 0 through GATE_CYCLES-1 and then wrap to 0; the wrap cycle is the terminal count (tc).
REQ-014 On a clock edge with enable=1 and no tc: if rise=1 and edge_cnt is below its maximum, edge_cnt SHALL increment by 1.
REQ-015 If edge_cnt is at 2^CNT_W-1 and rise=1, edge_cnt SHALL hold that value and the sat flag SHALL be set to 1.
REQ-016 On a clock edge with tc, count_out SHALL load min(edge_cnt+rise, 2^CNT_W-1), so an edge on the tc cycle belongs to the closing window.
REQ-017 On a tc edge, overflow SHALL load sat, or 1 if the tc-cycle edge itself saturates; edge_cnt and sat SHALL clear to 0; valid SHALL be 1 for exactly the following cycle.
REQ-018 Each window SHALL be exactly GATE_CYCLES cycles, with no dead cycle between windows.
REQ-019 While enable=0: gate_cnt, edge_cnt and sat SHALL be held at 0, valid SHALL be 0, and count_out and overflow SHALL hold their last values.
REQ-020 The synchronizer SHALL keep running while enable=0.
REQ-021 When enable goes from 0 to 1, a fresh window SHALL start with gate_cnt=0 at the first enabled edge; the first valid SHALL occur GATE_CYCLES cycles later.
REQ-022 Deasserting enable mid-window SHALL abandon that window: no valid pulse and no change to count_out.
REQ-023 The arithmetic width of gate_cnt SHALL be clog2(GATE_CYCLES); edge_cnt SHALL be CNT_W bits and never wrap.

Reset
REQ-024 While rst=0, count_out=0, valid=0, overflow=0, and gate_cnt, edge_cnt, sat, s1, s2 and s3 SHALL all be 0, regardless of clk.
REQ-025 Because s3 resets to 0, a sig_in held at 1 through reset release SHALL count as one edge in the first window.
REQ-026 Asserting reset mid-window SHALL discard the window immediately; no valid pulse SHALL be produced for it.

Verification (run with GATE_CYCLES=100 unless stated otherwise)
REQ-027 sig_in is a square wave of period 10 cycles and enable=1 -> every valid shows count_out=10 and overflow=0, and valid pulses are exactly 100 cycles apart.
REQ-028 sig_in is held at 0 -> count_out=0 at every valid; sig_in is then held at 1 from reset -> first window gives 1, later windows give 0.
REQ-029 CNT_W=4 and sig_in period 4 cycles -> count_out=15 and overflow=1; the period is then changed to 20 cycles -> the next full window gives count_out=5 and overflow=0.
REQ-030 rst pulled low at gate_cnt=50 -> outputs are 0 immediately with no valid pulse; after release, the first valid occurs 100 cycles later.
REQ-031 enable is dropped at gate_cnt=70 for 30 cycles and then raised -> count_out keeps its old value and there is no valid pulse; the next valid is 100 cycles after re-enable with a correct count.
REQ-032 A single sig_in edge is placed so that rise=1 on the tc cycle -> that edge is included in the closing window's count_out and not in the next window.
